spi_cmd_ctrl: RTL

Command sequencer placed directly behind the 16-bit SPI serial-to-parallel receiver. It consumes received words (`word`/`word_ready`), decodes them into register-bank write transactions (single write, burst write, bulk clear), and reports completion and frame errors. It owns all sequencing of the receive path. The register bank itself sits outside this block and sees only a simple write port.

---
 rtl/spi_ctrl_pkg.sv | 24 ++
 rtl/spi_cmd_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI command sequencer.
//   - 4-bit opcode constants carried in word[15:12]
//   - sequencer state encoding
//   - 2-bit error codes reported on err_code
package spi_ctrl_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_WRITE = 4'd1;
  localparam logic [3:0] OP_BURST = 4'd2;
  localparam logic [3:0] OP_CLEAR = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_BURST = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_OPCODE  = 2'd1;
  localparam logic [1:0] ERR_ABORT   = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

endpackage

// File: rtl/spi_cmd_ctrl.sv
// Command sequencer behind the 16-bit SPI SIPO. Turns received words into
// register-bank writes (single, burst, bulk clear) and reports completion
// and the first frame error.
//   clk, rst        : clock, async active-high reset
//   ss              : slave select, active-low, synchronous to clk
//   word/word_ready : SIPO word and its valid level
//   wr_en/wr_addr/wr_data : register-bank write port (one strobe per write)
//   busy            : burst or clear in progress
//   cmd_done        : one-cycle completion pulse
//   err/err_code    : first error of the current frame (sticky)
//   cmd_count       : completed commands, wraps at 8 bits
module spi_cmd_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter  int NUM_REGS = 16,
  parameter  int DATA_W   = 8,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss,
  input  logic [15:0]       word,
  input  logic              word_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              cmd_done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [7:0]        cmd_count
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t              state_q, state_d;
  logic                ss_q, rdy_q;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;   // burst address / clear index
  logic [3:0]          rem_q, rem_d;   // burst words still expected
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                err_set;
  logic [1:0]          err_val;

  logic                ss_fall, word_ev;
  logic [3:0]          op, cmd_addr, burst_n;
  logic [DATA_W-1:0]   din;

  assign ss_fall  = ss_q & ~ss;
  assign word_ev  = word_ready & ~rdy_q;   // a held level never re-triggers
  assign op       = word[15:12];
  assign cmd_addr = word[11:8];
  assign burst_n  = word[3:0];
  assign din      = word[DATA_W-1:0];

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ss_q       <= 1'b0;
      rdy_q      <= 1'b0;
      ptr_q      <= '0;
      rem_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ss_q       <= ss;
      rdy_q      <= word_ready;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      cnt_q      <= cnt_d;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    unique case (state_q)
      ST_IDLE: if (ss_fall) state_d = ST_CMD;
      ST_CMD: begin
        if (word_ev) begin
          if (op == OP_BURST && burst_n != 4'd0) begin
            state_d = ST_BURST;
            rem_d   = burst_n;
            ptr_d   = ADDR_W'(cmd_addr);
          end else if (op == OP_CLEAR) begin
            state_d = ST_CLEAR;
            ptr_d   = '0;
          end
        end
        // The word of this cycle is handled first; a clear it starts still
        // runs to completion before the frame closes.
        if (ss && state_d != ST_CLEAR) state_d = ST_IDLE;
      end
      ST_BURST: begin
        if (word_ev) begin
          ptr_d = ptr_q + ADDR_W'(1);
          rem_d = rem_q - 4'd1;
          if (rem_q == 4'd1) state_d = ST_CMD;
        end
        if (ss) state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == LAST_IDX) state_d = ss ? ST_IDLE : ST_CMD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_set   = 1'b0;
    err_val   = ERR_NONE;
    unique case (state_q)
      ST_IDLE: ;
      ST_CMD: begin
        if (word_ev) begin
          case (op)
            OP_NOP: done_d = 1'b1;
            OP_WRITE: begin
              wr_en_d   = 1'b1;
              wr_addr_d = ADDR_W'(cmd_addr);
              wr_data_d = din;
              done_d    = 1'b1;
            end
            OP_BURST: begin
              if (burst_n == 4'd0) begin
                err_set = 1'b1;
                err_val = ERR_OPCODE;
              end else if (ss) begin
                // burst opened and frame closed in the same cycle
                err_set = 1'b1;
                err_val = ERR_ABORT;
              end
            end
            OP_CLEAR: ;
            default: begin
              err_set = 1'b1;
              err_val = ERR_OPCODE;
            end
          endcase
        end
      end
      ST_BURST: begin
        if (word_ev) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = din;
          done_d    = (rem_q == 4'd1);
        end
        // a word that completes the burst beats a simultaneous ss rise
        if (ss && !(word_ev && rem_q == 4'd1)) begin
          err_set = 1'b1;
          err_val = ERR_ABORT;
        end
      end
      ST_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = ptr_q;
        wr_data_d = '0;
        done_d    = (ptr_q == LAST_IDX);
        if (word_ev) begin
          err_set = 1'b1;
          err_val = ERR_OVERRUN;
        end
      end
      default: ;
    endcase

    // busy tracks the clear writes exactly, and the burst state for bursts
    busy_d = (state_q == ST_CLEAR) || (state_d == ST_BURST);

    // clear at frame start, then keep only the first error of the frame
    err_d      = ss_fall ? 1'b0 : err_q;
    err_code_d = ss_fall ? ERR_NONE : err_code_q;
    if (err_set && !err_d) begin
      err_d      = 1'b1;
      err_code_d = err_val;
    end

    cnt_d = cnt_q + {7'd0, done_d};
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign cmd_done  = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign cmd_count = cnt_q;

endmodule
